cla_seq_adder: RTL and testbench



---
 rtl/cla_seq_adder.sv | 151 +++++++++++++++
 tb/tb_cla_seq_adder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle carry-lookahead adder.
// Each RUN cycle processes one 4-bit group through a 4-bit lookahead carry
// unit. The group carry-out is registered and feeds the next group.
// Optional macro CLA_SEQ_ADDER_SUB_EN adds a 'sub' input for a-b.
module cla_seq_adder #(
    parameter int WIDTH = 16,
    parameter int NGRP  = WIDTH / 4   // derived, do not override
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef CLA_SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int IW = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NGRP - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IW-1:0]    idx_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             busy_reg;
    logic             done_reg;

    // Values loaded into the operand/carry registers when start is accepted.
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef CLA_SEQ_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; cin is ignored when sub is set.
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : cin;
    end
`else
    // Addition only: load operands unchanged.
    always_comb begin
        b_load = b;
        c_load = cin;
    end
`endif

    // Bit offset of the group currently being processed.
    logic [IW+1:0] base;
    assign base = {idx_reg, 2'b00};

    logic [3:0] ga, gb;
    assign ga = a_reg[base +: 4];
    assign gb = b_reg[base +: 4];

    // Per-bit propagate and generate for the active group.
    logic [3:0] p, g;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pg
            assign p[gi] = ga[gi] ^ gb[gi];
            assign g[gi] = ga[gi] & gb[gi];
        end
    endgenerate

    // Lookahead carry unit: every carry is a flat two-level expression of
    // p, g and c0, so there is no ripple path inside the group.
    logic [4:0] c;
    always_comb begin
        c[0] = carry_reg;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
    end

    logic [3:0] grp_sum;
    assign grp_sum = p ^ c[3:0];

    // Control FSM with registered outputs; one group per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b_load;
                        carry_reg <= c_load;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[base +: 4] <= grp_sum;
                    carry_reg          <= c[4];
                    if (idx_reg == LAST_IDX) begin
                        cout_reg  <= c[4];
                        ovf_reg   <= c[4] ^ c[3];
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed-vector bench for cla_seq_adder (WIDTH=16).
// Subtraction vectors run only when CLA_SEQ_ADDER_SUB_EN is defined.
module tb_cla_seq_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef CLA_SEQ_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits edge by edge (sampling 1 time unit after each edge) for done.
    task automatic wait_done(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!done && edges < 20);
        if (!done) check("done_timeout", 32'(edges), 32'd4);
    endtask

    // One complete operation: accept, latency, result, single-cycle done.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic vs, input logic [15:0] es,
                          input logic ec, input logic eo);
        int edges;
        a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'hAAAA; b = 16'h5555; cin = ~vc;   // latched copies must be used
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(edges);
        check({tag, "_lat"}, 32'(edges), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk);
        #1;
        check({tag, "_done1"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        $display("op %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                 tag, va, vb, vc, vs, sum, cout, ovf);
    endtask

    initial begin
        int edges;
        // Asynchronous reset asserted between clock edges.
        #3 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_op("basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("cin12",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // start while busy is ignored; start held through DONE is taken in IDLE.
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'hAAAA; b = 16'h0000;      // start stays high through RUN and DONE
        wait_done(edges);
        check("ign_lat", 32'(edges), 32'd4);
        check("ign_sum", 32'(sum), 32'h0002);
        @(posedge clk);
        #1;
        check("ign_idle_busy", 32'(busy), 32'd0);
        check("ign_idle_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("held_accept", 32'(busy), 32'd1);
        wait_done(edges);
        check("held_lat", 32'(edges), 32'd4);
        check("held_sum", 32'(sum), 32'hAAAA);
        $display("op held: second op sum=%h", sum);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN aborts the op.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk);
                #1;
                if (done) seen++;
            end
            check("abort_nodone", 32'(seen), 32'd0);
        end
        $display("op abort: busy=%0d sum=%h", busy, sum);
        run_op("fresh", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef CLA_SEQ_ADDER_SUB_EN
        run_op("sub57", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub75", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("subovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
